// File: rtl/timer_display_scan.sv
// Scans three BCD timer digits onto a multiplexed 7-segment display (M:SS with dp
// on the minutes digit). Snapshots digits once per frame, blinks while paused.
module timer_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] seconds0,
  input  logic [3:0] seconds1,
  input  logic [3:0] minutes0,
  input  logic       paused,
  input  logic       enable,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done,
  output logic       err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
  localparam logic POL = ACTIVE_LOW;

  function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic legal);
    logic [6:0] c;
    c = 7'h40;
    if (legal) begin
      case (d)
        4'd0: c = 7'h3F;
        4'd1: c = 7'h06;
        4'd2: c = 7'h5B;
        4'd3: c = 7'h4F;
        4'd4: c = 7'h66;
        4'd5: c = 7'h6D;
        4'd6: c = 7'h7D;
        4'd7: c = 7'h07;
        4'd8: c = 7'h7F;
        4'd9: c = 7'h6F;
        default: c = 7'h40;
      endcase
    end
    return c;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    slot_q, slot_d;
  logic [11:0]   sample_q, sample_d;
  logic [11:0]   snap_q, snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;   // 1 = dark half-period
  logic          err_q, err_d;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick, frame_b, stable, dark;
  logic [11:0]   din;
  logic [2:0]    legal;
  logic [3:0]    digit;
  logic          digit_ok;
  logic [2:0]    an_raw;
  logic [6:0]    seg_raw;
  logic          dp_raw;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    frame_b = tick && (slot_q == 2'd2);
    presc_d = tick ? '0 : presc_q + 1'b1;
    slot_d  = slot_q;
    if (tick) slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;

    // Digits ripple in from the timer; only take a bundle that held for a full cycle.
    din      = {minutes0, seconds1, seconds0};
    sample_d = din;
    stable   = (din == sample_q);
    snap_d   = (frame_b && stable) ? din : snap_q;

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!paused) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_b) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    legal[0] = (snap_q[3:0]  <= 4'd9);
    legal[1] = (snap_q[7:4]  <= 4'd5);
    legal[2] = (snap_q[11:8] <= 4'd9);
    err_d    = ~&legal;

    case (slot_q)
      2'd1:    begin digit = snap_q[7:4];  digit_ok = legal[1]; an_raw = 3'b010; end
      2'd2:    begin digit = snap_q[11:8]; digit_ok = legal[2]; an_raw = 3'b100; end
      default: begin digit = snap_q[3:0];  digit_ok = legal[0]; an_raw = 3'b001; end
    endcase
    seg_raw = seg_decode(digit, digit_ok);
    dp_raw  = (slot_q == 2'd2);

    // Gating with live paused means unpausing lights the display on the next edge.
    dark = (phase_q && paused) || !enable;
    if (dark) begin
      an_raw  = 3'b000;
      seg_raw = 7'h00;
      dp_raw  = 1'b0;
    end
    an_d  = an_raw ^ {3{POL}};
    seg_d = seg_raw ^ {7{POL}};
    dp_d  = dp_raw ^ POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      slot_q      <= 2'd0;
      sample_q    <= '0;
      snap_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      err_q       <= 1'b0;
      an_q        <= {3{POL}};
      seg_q       <= {7{POL}};
      dp_q        <= POL;
    end else begin
      presc_q     <= presc_d;
      slot_q      <= slot_d;
      sample_q    <= sample_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      err_q       <= err_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign err        = err_q;
  assign frame_done = frame_b;

endmodule

// File: tb/tb_timer_display_scan.sv
// Directed bench for timer_display_scan with SCAN_DIV=4, BLINK_FRAMES=2, active-high outputs.
module tb_timer_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] seconds0 = 4'd0, seconds1 = 4'd0, minutes0 = 4'd0;
  logic       paused = 1'b0, enable = 1'b1;
  logic [2:0] an;
  logic [6:0] seg;
  logic       dp, frame_done, err;

  int vectors = 0;
  int miscompares = 0;
  int n;

  timer_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .seconds0(seconds0), .seconds1(seconds1),
    .minutes0(minutes0), .paused(paused), .enable(enable), .an(an), .seg(seg),
    .dp(dp), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    while (!frame_done && cyc < 40) begin
      step(1);
      cyc++;
    end
    if (!frame_done) chk("frame_timeout", 16'(frame_done), 16'd1);
  endtask

  // Called in a boundary cycle; checks the following frame and returns at the next boundary.
  task automatic check_frame(input string tag, input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic e_prev, input logic e_new);
    step(1);
    chk({tag, "_an_tail"}, 16'(an), 16'b100);
    chk({tag, "_err_prev"}, 16'(err), 16'(e_prev));
    step(1);
    chk({tag, "_an0"}, 16'(an), 16'b001);
    chk({tag, "_seg0"}, 16'(seg), 16'(c0));
    chk({tag, "_dp0"}, 16'(dp), 16'd0);
    chk({tag, "_err_new"}, 16'(err), 16'(e_new));
    step(4);
    chk({tag, "_an1"}, 16'(an), 16'b010);
    chk({tag, "_seg1"}, 16'(seg), 16'(c1));
    chk({tag, "_dp1"}, 16'(dp), 16'd0);
    step(4);
    chk({tag, "_an2"}, 16'(an), 16'b100);
    chk({tag, "_seg2"}, 16'(seg), 16'(c2));
    chk({tag, "_dp2"}, 16'(dp), 16'd1);
    step(2);
    chk({tag, "_fdone"}, 16'(frame_done), 16'd1);
  endtask

  initial begin
    // 1: reset state and idle scan of 0/0/0
    step(2);
    chk("rst_an", 16'(an), 16'd0);
    chk("rst_seg", 16'(seg), 16'd0);
    chk("rst_dp", 16'(dp), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_fdone", 16'(frame_done), 16'd0);
    reset = 1'b0;
    step(1);
    chk("t1_first_an", 16'(an), 16'b001);
    chk("t1_first_seg", 16'(seg), 16'h3F);
    wait_frame(n);
    chk("t1_first_frame_len", 16'(n), 16'd10);
    check_frame("t1", 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0);

    // 2: mid-frame change waits for the next boundary
    step(1);
    seconds0 = 4'd7; seconds1 = 4'd3; minutes0 = 4'd2;
    step(1);
    chk("t2_old_seg", 16'(seg), 16'h3F);
    wait_frame(n);
    check_frame("t2", 7'h07, 7'h4F, 7'h5B, 1'b0, 1'b0);

    // 3: change on the boundary cycle itself is not stable -> one extra frame of old digits
    seconds0 = 4'd1; seconds1 = 4'd5; minutes0 = 4'd9;
    check_frame("t3_held", 7'h07, 7'h4F, 7'h5B, 1'b0, 1'b0);
    check_frame("t3_new", 7'h06, 7'h6D, 7'h6F, 1'b0, 1'b0);

    // 4: illegal seconds tens, then recovery, then illegal units
    step(1);
    seconds1 = 4'd6;
    wait_frame(n);
    check_frame("t4_s1_6", 7'h06, 7'h40, 7'h6F, 1'b0, 1'b1);
    step(1);
    seconds1 = 4'd5;
    wait_frame(n);
    check_frame("t4_s1_5", 7'h06, 7'h6D, 7'h6F, 1'b1, 1'b0);
    step(1);
    seconds0 = 4'd10;
    wait_frame(n);
    check_frame("t4_s0_a", 7'h40, 7'h6D, 7'h6F, 1'b0, 1'b1);

    // 5: blink while paused
    step(1);
    paused = 1'b1;
    wait_frame(n);
    step(2);
    chk("t5_vis_a", 16'(an), 16'b001);
    wait_frame(n);
    step(1);
    chk("t5_tail", 16'(an), 16'b100);
    step(1);
    chk("t5_dark_an", 16'(an), 16'd0);
    chk("t5_dark_seg", 16'(seg), 16'd0);
    chk("t5_dark_dp", 16'(dp), 16'd0);
    step(10);
    chk("t5_dark_fdone", 16'(frame_done), 16'd1);
    chk("t5_dark_an2", 16'(an), 16'd0);
    step(12);
    chk("t5_dark_fdone2", 16'(frame_done), 16'd1);
    chk("t5_dark_an3", 16'(an), 16'd0);
    step(1);
    chk("t5_dark_an4", 16'(an), 16'd0);
    step(1);
    chk("t5_vis_b_an", 16'(an), 16'b001);
    chk("t5_vis_b_seg", 16'(seg), 16'h40);
    step(22);
    chk("t5_vis_end_fdone", 16'(frame_done), 16'd1);
    chk("t5_vis_end_an", 16'(an), 16'b100);
    step(2);
    chk("t5_dark_c", 16'(an), 16'd0);
    step(1);
    chk("t5_dark_c2", 16'(an), 16'd0);
    paused = 1'b0;
    step(2);
    chk("t5_unpause_an", 16'(an), 16'b001);
    chk("t5_unpause_seg", 16'(seg), 16'h40);
    step(1);
    chk("t5_unpause_an1", 16'(an), 16'b010);
    chk("t5_err_before_rst", 16'(err), 16'd1);

    // 6: reset mid-slot-1, then disable
    reset = 1'b1;
    seconds0 = 4'd0; seconds1 = 4'd0; minutes0 = 4'd0;
    step(1);
    chk("t6_rst_an", 16'(an), 16'd0);
    chk("t6_rst_seg", 16'(seg), 16'd0);
    chk("t6_rst_dp", 16'(dp), 16'd0);
    chk("t6_rst_err", 16'(err), 16'd0);
    reset = 1'b0;
    step(1);
    chk("t6_restart_an", 16'(an), 16'b001);
    chk("t6_restart_seg", 16'(seg), 16'h3F);
    wait_frame(n);
    chk("t6_restart_len", 16'(n), 16'd10);
    enable = 1'b0;
    step(2);
    chk("t6_dis_an", 16'(an), 16'd0);
    chk("t6_dis_seg", 16'(seg), 16'd0);
    chk("t6_dis_dp", 16'(dp), 16'd0);
    step(4);
    chk("t6_dis_an_b", 16'(an), 16'd0);
    wait_frame(n);
    chk("t6_dis_frame_len", 16'(n), 16'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_display_scan.md
Name: timer_display_scan

Overview:
Downstream consumer of the playback timer's BCD digits (seconds0, seconds1, minutes0). Captures a tear-free snapshot of the three digits once per scan frame and drives a 3-digit multiplexed 7-segment display. The minutes digit carries the decimal point as the M:SS separator. Blinks the display while playback is paused and flags out-of-range digits.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (min 2)
BLINK_FRAMES, 64, scan frames per blink half-period (min 1)
ACTIVE_LOW, 1, 1 = active segment/anode/dp driven 0; 0 = driven 1

Ports:
clk  in  1  system clock, sole clock
reset  in  1  synchronous, active-high
seconds0  in  4  BCD seconds units from timer (0-9 legal)
seconds1  in  4  BCD seconds tens from timer (0-5 legal)
minutes0  in  4  BCD minutes from timer (0-9 legal)
paused  in  1  1 = blink display
enable  in  1  0 = blank all digits, scanning continues
an  out  3  digit anodes: an[0]=seconds0, an[1]=seconds1, an[2]=minutes0
seg  out  7  segments, seg[0]=a .. seg[6]=g
dp  out  1  decimal point, active only in minutes slot
frame_done  out  1  one-cycle pulse at each frame boundary
err  out  1  snapshot holds an illegal digit

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset:
  - prescaler=0, slot=0, snapshot=0/0/0, blink counter=0, blink phase=visible.
  - an, seg, dp all inactive per ACTIVE_LOW. frame_done=0, err=0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. Slot tick when count==SCAN_DIV-1.
- Slot: advances 0->1->2->0 on slot tick. Frame boundary = tick while slot==2; frame_done pulses that cycle.
- Input sampling:
  - The 12-bit digit bundle is registered every cycle into sample_q.
  - The bundle is "stable" when the current inputs equal sample_q.
  - At the frame boundary, snapshot<=inputs only if stable; otherwise the old snapshot is held for one more frame. This absorbs the timer's rippled digit updates.
- Decode (active-high codes, hex, bit6..0 = g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Illegal value shows dash=40. Illegal means any value >9, or seconds1 >5.
  - With ACTIVE_LOW=1, all of an/seg/dp are inverted.
- err: registered. Equals OR of the illegal conditions on the current snapshot. Updates the cycle after the snapshot changes.
- Blink:
  - paused=1: blink counter counts frame boundaries 0..BLINK_FRAMES-1; at wrap, phase toggles.
  - paused=0: counter cleared and phase=visible combinationally on the next cycle, so the display is never dark after unpause.
- Outputs: registered. They reflect slot/snapshot/phase of the previous cycle, so an/seg change exactly 1 cycle after a slot tick.
- Exactly one anode is active per cycle when visible. None is active when phase=dark, enable=0, or in the first cycle after reset.
- Dark/disabled: seg and dp are also inactive.
- dp: active when slot==2 and visible.
- reset has priority over every other event. Reset mid-frame restarts at slot 0 with prescaler 0 and clears the snapshot.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=0, enable=1, paused=0 unless stated):
1. Reset, inputs 0/0/0 -> an cycles 001,010,100 every 4 cycles; seg=3F each slot; dp=1 only with an=100; frame_done every 12 cycles.
2. Inputs s0=7, s1=3, m0=2, held stable -> after the next frame boundary: an=001/seg=07, an=010/seg=4F, an=100/seg=5B/dp=1; err=0.
3. Inputs change mid-frame -> displayed values change only after the next frame boundary. Change inputs exactly on the boundary cycle (not stable) -> old digits shown for one more full frame, new digits the frame after.
4. seconds1=6 (others legal) -> slot 1 shows seg=40; err=1 one cycle after the snapshot update. Return to 5 -> err=0 after the next boundary.
5. paused=1 -> an=000 for 2 frames, scanning for 2 frames, repeating. Drop paused while dark -> an active again on the next slot output.
6. reset pulsed mid-slot-1 -> next cycle an/seg/dp=0 and err=0; scan restarts at slot 0 showing 0. enable=0 -> an=000, seg=00, frame_done still pulses.
